// File: rtl/door_sensor_frontend_if.sv
// Raw door hardware inputs and cleaned request outputs of door_sensor_frontend.
// FAULT exists only when DOOR_FAULT_EN is defined.
interface door_sensor_frontend_if;
  logic BEAM_A;
  logic BEAM_B;
  logic BTN;
  logic IN;
  logic OUT;
  logic ENT;
`ifdef DOOR_FAULT_EN
  logic FAULT;
`endif

  modport master (
    output BEAM_A, BEAM_B, BTN,
    input  IN, OUT, ENT
`ifdef DOOR_FAULT_EN
    , input FAULT
`endif
  );

  modport slave (
    input  BEAM_A, BEAM_B, BTN,
    output IN, OUT, ENT
`ifdef DOOR_FAULT_EN
    , output FAULT
`endif
  );
endinterface

// File: rtl/door_sensor_frontend.sv
// Synchronizes and debounces the door beams and button, then resolves passage direction into
// single-cycle IN/OUT/ENT pulses. Macro DOOR_FAULT_EN adds the FAULT output and dwell timeout.
module door_sensor_frontend #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic                   clk,
  input logic                   CLR,
  door_sensor_frontend_if.slave bus
);

  localparam logic [7:0] DebLast = 8'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
    $error("door_sensor_frontend: DEB_CYCLES or TIMEOUT out of range");
  end

  typedef enum logic [2:0] {
    StIdle,
    StAFirst,
    StInAb,
    StInB,
    StBFirst,
    StOutBa,
    StOutA,
    StFlt
  } state_e;

  // Bit 0 = beam A, bit 1 = beam B, bit 2 = button.
  logic [2:0] raw;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] filt_q;
  logic [2:0] filt_d;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  logic       fa;
  logic       fb;
  logic       btn_prev_q;

  state_e     state_q;
  state_e     state_d;
  logic       in_q;
  logic       in_d;
  logic       out_q;
  logic       out_d;
  logic       ent_q;
  logic       ent_d;

  assign raw = {bus.BTN, bus.BEAM_B, bus.BEAM_A};
  assign fa  = filt_q[0];
  assign fb  = filt_q[1];

  // Debounce: a filtered level flips only after DEB_CYCLES consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == DebLast) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      btn_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      btn_prev_q <= filt_q[2];
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ent_d = filt_q[2] & ~btn_prev_q;

`ifdef DOOR_FAULT_EN
  localparam logic [15:0] TimeoutLim  = 16'(TIMEOUT);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] dwell_q;
  logic [15:0] dwell_d;
  logic        fault_q;
  logic        fault_d;
`endif

  // Passage direction FSM on the filtered beams.
  always_comb begin
    state_d = state_q;
    in_d    = 1'b0;
    out_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fa && !fb) begin
          state_d = StAFirst;
        end else if (!fa && fb) begin
          state_d = StBFirst;
        end else if (fa && fb) begin
          state_d = StFlt;
        end
      end
      StAFirst: begin
        if (fa && fb) begin
          state_d = StInAb;
        end else if (!fa && !fb) begin
          state_d = StIdle;
        end
      end
      StInAb: begin
        if (!fa && fb) begin
          state_d = StInB;
        end else if (fa && !fb) begin
          state_d = StAFirst;
        end
      end
      StInB: begin
        if (!fa && !fb) begin
          state_d = StIdle;
          in_d    = 1'b1;
        end else if (fa && fb) begin
          state_d = StInAb;
        end
      end
      StBFirst: begin
        if (fa && fb) begin
          state_d = StOutBa;
        end else if (!fa && !fb) begin
          state_d = StIdle;
        end
      end
      StOutBa: begin
        if (fa && !fb) begin
          state_d = StOutA;
        end else if (!fa && fb) begin
          state_d = StBFirst;
        end
      end
      StOutA: begin
        if (!fa && !fb) begin
          state_d = StIdle;
          out_d   = 1'b1;
        end else if (fa && fb) begin
          state_d = StOutBa;
        end
      end
      StFlt: begin
        if (!fa && !fb) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef DOOR_FAULT_EN
    // Dwell only accumulates while a passage is parked in one tracking state.
    dwell_d = '0;
    if (state_d == state_q && state_q != StIdle && state_q != StFlt) begin
      if (dwell_q == TimeoutLast) begin
        state_d = StFlt;
      end else if (dwell_q < TimeoutLim) begin
        dwell_d = dwell_q + 16'd1;
      end else begin
        dwell_d = dwell_q;
      end
    end
    fault_d = (state_d == StFlt);
`endif
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= StIdle;
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      ent_q   <= 1'b0;
`ifdef DOOR_FAULT_EN
      dwell_q <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      ent_q   <= ent_d;
`ifdef DOOR_FAULT_EN
      dwell_q <= dwell_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign bus.IN  = in_q;
  assign bus.OUT = out_q;
  assign bus.ENT = ent_q;
`ifdef DOOR_FAULT_EN
  assign bus.FAULT = fault_q;
`endif

endmodule
